// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
//   AHB-Lite slave fronting a single-port word-organised SRAM.
//   - Two-stage AHB pipeline: the address phase is captured when HSEL, HREADY and an
//     active HTRANS (NONSEQ/SEQ) coincide; the data phase follows.
//   - WAIT_STATES inserts that many HREADYOUT=0 cycles before an OKAY data phase completes.
//   - Writes commit byte lanes on the completing data-phase edge.
//   - Reads are captured at the address-phase edge. A write committing on that same edge
//     is merged in lane by lane.
//   - Optional error checking is enabled by defining the macro AHB_SRAM_ERR_RESP_EN:
//     oversize HSIZE, misaligned HADDR and out-of-range HADDR each get a two-cycle ERROR.
//     Without it HRESP is tied low and addresses wrap modulo the memory size.
//
// Parameters
//   DATAWIDTH   : 32 or 64, HWDATA/HRDATA width
//   ADDRWIDTH   : HADDR width
//   MEM_DEPTH   : words of storage, power of two
//   WAIT_STATES : 0..15 data-phase wait cycles for OKAY transfers
//
// Ports
//   HCLK, HRESET            : clock, synchronous active-high reset
//   HSEL, HADDR, HWRITE,
//   HSIZE, HBURST, HTRANS   : address-phase controls (HBURST is accepted but not used)
//   HWDATA                  : write data, valid in the data phase
//   HREADY                  : bus-level ready
//   HREADYOUT, HRDATA, HRESP: slave response
module ahb_sram_slave #(
  parameter int unsigned DATAWIDTH   = 32,
  parameter int unsigned ADDRWIDTH   = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 HSEL,
  input  logic [ADDRWIDTH-1:0] HADDR,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [2:0]           HBURST,
  input  logic [1:0]           HTRANS,
  input  logic [DATAWIDTH-1:0] HWDATA,
  input  logic                 HREADY,
  output logic                 HREADYOUT,
  output logic [DATAWIDTH-1:0] HRDATA,
  output logic                 HRESP
);

  localparam int unsigned Lanes    = DATAWIDTH / 8;
  localparam int unsigned OffW     = $clog2(Lanes);
  localparam int unsigned IdxW     = $clog2(MEM_DEPTH);
  localparam logic [3:0]  WaitInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

  state_e                state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  dp_valid_q, dp_valid_d;
  logic                  dp_write_q, dp_write_d;
  logic [OffW-1:0]       dp_off_q, dp_off_d;
  logic [IdxW-1:0]       dp_idx_q, dp_idx_d;
  logic [2:0]            dp_size_q, dp_size_d;
  logic [DATAWIDTH-1:0]  rdata_q, rdata_d;

  logic [DATAWIDTH-1:0]  mem [MEM_DEPTH];

  logic                  accept;
  logic                  err_xfer;
  logic                  complete;
  logic                  wr_commit;
  logic [Lanes-1:0]      wr_mask;
  logic [IdxW-1:0]       addr_idx;
  logic [OffW-1:0]       addr_off;
  logic [DATAWIDTH-1:0]  fwd_word;

  // HBURST carries no behaviour here; upper HADDR bits only matter with error checking.
  logic                  unused_inputs;
  assign unused_inputs = ^{HBURST, HADDR};

  // Lane i belongs to the access if it sits in the same 2^size-byte block as the offset.
  // Oversize or misaligned requests therefore degrade to the enclosing aligned block.
  function automatic logic [Lanes-1:0] lane_mask(input logic [OffW-1:0] off,
                                                  input logic [2:0]      size);
    logic [Lanes-1:0] m;
    for (int i = 0; i < Lanes; i++) begin
      m[i] = ((OffW'(i) >> size) == (off >> size));
    end
    return m;
  endfunction

  assign accept   = HSEL & HREADY & HTRANS[1];
  assign addr_idx = HADDR[OffW +: IdxW];
  assign addr_off = HADDR[OffW-1:0];

`ifdef AHB_SRAM_ERR_RESP_EN
  localparam logic [2:0]         MaxSize  = 3'(OffW);
  localparam logic [ADDRWIDTH:0] MemBytes = (ADDRWIDTH + 1)'(MEM_DEPTH * Lanes);

  logic [ADDRWIDTH-1:0] align_mask;

  always_comb begin
    align_mask = (ADDRWIDTH'(1) << HSIZE) - ADDRWIDTH'(1);
    err_xfer   = (HSIZE > MaxSize) | (|(HADDR & align_mask)) | ({1'b0, HADDR} >= MemBytes);
  end

  assign HRESP = (state_q == StErr1) || (state_q == StErr2);
`else
  assign err_xfer = 1'b0;
  assign HRESP    = 1'b0;
`endif

  // An OKAY data phase completes in the first StIdle cycle after its address phase.
  assign complete  = dp_valid_q && (state_q == StIdle);
  assign wr_commit = complete && dp_write_q && !HRESET;
  assign wr_mask   = lane_mask(dp_off_q, dp_size_q);

  // The read is registered at its address-phase edge, which is also the edge on which a
  // preceding write commits; merge that write's lanes so the read sees the new data.
  always_comb begin
    fwd_word = mem[addr_idx];
    if (wr_commit && (dp_idx_q == addr_idx)) begin
      for (int i = 0; i < Lanes; i++) begin
        if (wr_mask[i]) begin
          fwd_word[8*i +: 8] = HWDATA[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_off_d   = dp_off_q;
    dp_idx_d   = dp_idx_q;
    dp_size_d  = dp_size_q;
    rdata_d    = rdata_q;

    case (state_q)
      StWait: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      StErr1: begin
        state_d = StErr2;
      end
      default: begin
        // StIdle and StErr2 both drive HREADYOUT=1, so a new address phase may land here.
        state_d    = StIdle;
        dp_valid_d = accept & ~err_xfer;
        if (accept) begin
          dp_write_d = HWRITE;
          dp_off_d   = addr_off;
          dp_idx_d   = addr_idx;
          dp_size_d  = HSIZE;
          if (err_xfer) begin
            state_d = StErr1;
          end else begin
            if (!HWRITE) begin
              rdata_d = fwd_word;
            end
            if (WAIT_STATES > 0) begin
              state_d    = StWait;
              wait_cnt_d = WaitInit;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= StIdle;
      wait_cnt_q <= 4'd0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_off_q   <= '0;
      dp_idx_q   <= '0;
      dp_size_q  <= 3'd0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_off_q   <= dp_off_d;
      dp_idx_q   <= dp_idx_d;
      dp_size_q  <= dp_size_d;
      rdata_q    <= rdata_d;
    end
  end

  // Storage is deliberately left uninitialised.
  always_ff @(posedge HCLK) begin
    if (wr_commit) begin
      for (int i = 0; i < Lanes; i++) begin
        if (wr_mask[i]) begin
          mem[dp_idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    if ((state_q == StWait) || (state_q == StErr1)) begin
      HREADYOUT = 1'b0;
    end
    HRDATA = (complete && !dp_write_q) ? rdata_q : '0;
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (WAIT_STATES 0 and 3) run the same vector table
// back to back. A scoreboard queue holds the expected completion of each accepted
// transfer, and a negedge monitor pops and compares it. Hand-written sequences cover
// inactive transfers and a reset landing inside a wait state.
module tb_ahb_sram_slave;

`ifdef AHB_SRAM_ERR_RESP_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  hsel, hwrite, hreadyout, hresp;
  logic [31:0] haddr  [2];
  logic [2:0]  hsize  [2];
  logic [2:0]  hburst [2];
  logic [1:0]  htrans [2];
  logic [31:0] hwdata [2];
  logic [31:0] hrdata [2];

  always #5 clk = ~clk;

  ahb_sram_slave #(.DATAWIDTH(32), .ADDRWIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel[0]), .HADDR(haddr[0]), .HWRITE(hwrite[0]),
    .HSIZE(hsize[0]), .HBURST(hburst[0]), .HTRANS(htrans[0]), .HWDATA(hwdata[0]),
    .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]), .HRDATA(hrdata[0]), .HRESP(hresp[0])
  );

  ahb_sram_slave #(.DATAWIDTH(32), .ADDRWIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_dut1 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel[1]), .HADDR(haddr[1]), .HWRITE(hwrite[1]),
    .HSIZE(hsize[1]), .HBURST(hburst[1]), .HTRANS(htrans[1]), .HWDATA(hwdata[1]),
    .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]), .HRDATA(hrdata[1]), .HRESP(hresp[1])
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } vec_t;

  typedef struct {
    int          unit;
    int          id;
    logic [31:0] rdata;
    bit          resp;
    int          waits;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   dphase [2];
  int   waits  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input bit err);
    vecs.push_back('{wr, addr, size, wdata, rdata, err});
  endfunction

  // Scoreboard monitor: counts wait cycles of the open data phase and checks completion.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (dphase[u]) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_empty: got completion on unit %0d expected none", u);
          dphase[u] = 1'b0;
        end else if (!hreadyout[u]) begin
          waits[u]++;
          check($sformatf("u%0d_vec%0d_wait_hresp", u, exp_q[0].id), 32'(hresp[u]),
                32'(exp_q[0].resp));
          check($sformatf("u%0d_vec%0d_wait_hrdata", u, exp_q[0].id), hrdata[u], 32'h0);
          if (waits[u] > 20) begin
            n_cmp++;
            n_fail++;
            $display("FAIL u%0d_wait_timeout: got %0d waits expected %0d", u, waits[u],
                     exp_q[0].waits);
            void'(exp_q.pop_front());
            dphase[u] = 1'b0;
          end
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check($sformatf("u%0d_vec%0d_unit", u, e.id), 32'(u), 32'(e.unit));
          check($sformatf("u%0d_vec%0d_hrdata", u, e.id), hrdata[u], e.rdata);
          check($sformatf("u%0d_vec%0d_hresp", u, e.id), 32'(hresp[u]), 32'(e.resp));
          check($sformatf("u%0d_vec%0d_waits", u, e.id), 32'(waits[u]), 32'(e.waits));
          dphase[u] = 1'b0;
        end
      end
    end
  end

  // Issue one address phase (entered #1 after a posedge) and hold it until accepted.
  task automatic xfer(input int u, input vec_t v, input int id);
    bit ok;
    int guard;
    hsel[u]   = 1'b1;
    htrans[u] = 2'b10;
    haddr[u]  = v.addr;
    hwrite[u] = v.wr;
    hsize[u]  = v.size;
    hburst[u] = 3'd0;
    guard     = 0;
    do begin
      @(negedge clk);
      ok = hreadyout[u];
      @(posedge clk);
      #1;
      guard++;
    end while (!ok && guard < 50);
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL u%0d_vec%0d_accept: got no HREADYOUT expected acceptance", u, id);
    end else begin
      exp_q.push_back('{u, id, (v.wr || v.err) ? 32'h0 : v.rdata, v.err,
                        v.err ? 1 : ((u == 1) ? 3 : 0)});
      dphase[u] = 1'b1;
      waits[u]  = 0;
      hwdata[u] = v.wr ? v.wdata : $urandom;
    end
    hsel[u]   = 1'b0;
    htrans[u] = 2'b00;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_drain: got %0d pending expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      hsel[u] = 1'b0; hwrite[u] = 1'b0; haddr[u] = '0; hsize[u] = '0;
      hburst[u] = '0; htrans[u] = '0; hwdata[u] = '0; dphase[u] = 1'b0; waits[u] = 0;
    end

    // Expected contents are built by hand from the write sequence above each read.
    add(1, 32'h10,  3'd2, 32'hDEADBEEF, 32'h0, 0);
    add(0, 32'h10,  3'd2, 32'h0, 32'hDEADBEEF, 0);
    add(1, 32'h10,  3'd2, 32'h11223344, 32'h0, 0);
    add(1, 32'h13,  3'd0, 32'hAA000000, 32'h0, 0);
    add(0, 32'h10,  3'd2, 32'h0, 32'hAA223344, 0);
    add(1, 32'h14,  3'd2, 32'h00000000, 32'h0, 0);
    add(1, 32'h16,  3'd1, 32'hCAFE0000, 32'h0, 0);
    add(1, 32'h14,  3'd0, 32'h00000055, 32'h0, 0);
    add(0, 32'h14,  3'd2, 32'h0, 32'hCAFE0055, 0);
    add(1, 32'h20,  3'd2, 32'h00000005, 32'h0, 0);
    add(0, 32'h20,  3'd2, 32'h0, 32'h00000005, 0);
    add(1, 32'h21,  3'd0, 32'h00007700, 32'h0, 0);
    add(0, 32'h20,  3'd2, 32'h0, 32'h00007705, 0);
    add(1, 32'h0,   3'd2, 32'h0BADF00D, 32'h0, 0);
    add(1, 32'h4,   3'd2, 32'h00000001, 32'h0, 0);
    add(0, 32'h400, 3'd2, 32'h0, ErrEn ? 32'h0 : 32'h0BADF00D, ErrEn);
    add(1, 32'h404, 3'd2, 32'h12345678, 32'h0, ErrEn);
    add(0, 32'h4,   3'd2, 32'h0, ErrEn ? 32'h1 : 32'h12345678, 0);
    add(0, 32'h11,  3'd2, 32'h0, ErrEn ? 32'h0 : 32'hAA223344, ErrEn);
    add(0, 32'h12,  3'd1, 32'h0, 32'hAA223344, 0);
    add(0, 32'h10,  3'd3, 32'h0, ErrEn ? 32'h0 : 32'hAA223344, ErrEn);
    add(1, 32'h3FC, 3'd2, 32'hFFFF0000, 32'h0, 0);
    add(0, 32'h3FC, 3'd2, 32'h0, 32'hFFFF0000, 0);

    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("u%0d_rst_hreadyout", u), 32'(hreadyout[u]), 32'h1);
      check($sformatf("u%0d_rst_hresp", u), 32'(hresp[u]), 32'h0);
      check($sformatf("u%0d_rst_hrdata", u), hrdata[u], 32'h0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("u%0d_post_rst_hreadyout", u), 32'(hreadyout[u]), 32'h1);
      check($sformatf("u%0d_post_rst_hrdata", u), hrdata[u], 32'h0);
    end

    // Table, issued back to back so every address phase overlaps the previous data phase.
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < vecs.size(); i++) begin
        xfer(u, vecs[i], i);
      end
      drain($sformatf("table_u%0d", u));
    end

    // Deselected write, then IDLE and BUSY while selected: all zero-wait, no access.
    hsel[1] = 1'b0; htrans[1] = 2'b10; hwrite[1] = 1'b1; haddr[1] = 32'h10; hsize[1] = 3'd2;
    @(posedge clk);
    #1;
    hwdata[1] = 32'hFFFFFFFF; hsel[1] = 1'b1; htrans[1] = 2'b00;
    @(negedge clk);
    check("desel_hreadyout", 32'(hreadyout[1]), 32'h1);
    check("desel_hresp", 32'(hresp[1]), 32'h0);
    @(posedge clk);
    #1;
    htrans[1] = 2'b01;
    @(negedge clk);
    check("idle_hreadyout", 32'(hreadyout[1]), 32'h1);
    @(posedge clk);
    #1;
    hsel[1] = 1'b0; htrans[1] = 2'b00;
    @(negedge clk);
    check("busy_hreadyout", 32'(hreadyout[1]), 32'h1);
    check("busy_hrdata", hrdata[1], 32'h0);
    @(posedge clk);
    #1;
    v = '{0, 32'h10, 3'd2, 32'h0, 32'hAA223344, 0};
    xfer(1, v, 100);
    drain("inactive");

    // Reset in the second wait cycle of a write must leave the target word untouched.
    hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1; haddr[1] = 32'h20; hsize[1] = 3'd2;
    @(posedge clk);
    #1;
    hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'hBAD0BAD0;
    @(negedge clk);
    check("rstwait_w1_hreadyout", 32'(hreadyout[1]), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstwait_w2_hreadyout", 32'(hreadyout[1]), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstwait_hreadyout", 32'(hreadyout[1]), 32'h1);
    check("rstwait_hresp", 32'(hresp[1]), 32'h0);
    check("rstwait_hrdata", hrdata[1], 32'h0);
    @(posedge clk);
    #1;
    v = '{0, 32'h20, 3'd2, 32'h0, 32'h00007705, 0};
    xfer(1, v, 101);
    drain("rstwait");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, HWDATA/HRDATA width; legal values are 32 and 64.
REQ-002 SHALL have parameter ADDRWIDTH, default 32, HADDR width.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, storage depth in DATAWIDTH-bit words; must be a power of 2.
REQ-004 SHALL have parameter WAIT_STATES, default 0, data-phase wait cycles for OKAY transfers; range 0..15.
REQ-005 SHALL have HCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have HRESET, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have HSEL, input, 1 bit: slave select.
REQ-008 SHALL have HADDR, input, ADDRWIDTH bits: byte address.
REQ-009 SHALL have HWRITE, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have HSIZE, input, 3 bits: transfer size, 2^HSIZE bytes.
REQ-011 SHALL have HBURST, input, 3 bits: burst type; accepted, not acted on.
REQ-012 SHALL have HTRANS, input, 2 bits: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-013 SHALL have HWDATA, input, DATAWIDTH bits: write data, valid in the data phase.
REQ-014 SHALL have HREADY, input, 1 bit: bus-level ready from the interconnect.
REQ-015 SHALL have HREADYOUT, output, 1 bit: slave ready.
REQ-016 SHALL have HRDATA, output, DATAWIDTH bits: read data.
REQ-017 SHALL have HRESP, output, 1 bit: 0 = OKAY, 1 = ERROR.

Function
REQ-018 Address phase SHALL be sampled only when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ; the sample captures HADDR, HWRITE, HSIZE.
REQ-019 When HSEL=0, or HTRANS is IDLE or BUSY, the next data phase SHALL be zero-wait OKAY: HREADYOUT=1, HRESP=0, no memory access.
REQ-020 FSM states SHALL be IDLE, WAIT, ERR1, ERR2.
REQ-021 IDLE->WAIT SHALL occur on a valid OKAY transfer when WAIT_STATES>0; WAIT holds HREADYOUT=0 for exactly WAIT_STATES cycles, then completes with HREADYOUT=1.
REQ-022 With WAIT_STATES=0, a valid transfer SHALL complete in the cycle after its address phase.
REQ-023 Writes SHALL update only the byte lanes selected by HSIZE and HADDR[log2(DATAWIDTH/8)-1:0] (little-endian), on the completing data-phase edge.
REQ-024 Read HRDATA SHALL be valid in the cycle HREADYOUT=1 completes the read; at all other times HRDATA SHALL be 0.
REQ-025 A read whose address phase overlaps the data phase of a write to the same word SHALL return the merged new data (write forwarding).
REQ-026 Word index SHALL be HADDR[log2(DATAWIDTH/8) +: log2(MEM_DEPTH)].
REQ-027 A new address phase SHALL be accepted in the same cycle HREADYOUT=1 completes the prior transfer (pipelined back-to-back).
REQ-028 Memory contents after reset SHALL be undefined; no initialisation is performed.

Reset
REQ-029 On HCLK edge with HRESET=1, the FSM SHALL go to IDLE and clear the wait counter and any captured address phase.
REQ-030 During and after reset, HREADYOUT SHALL be 1, HRESP 0, HRDATA 0.
REQ-031 A reset asserted mid-WAIT or mid-ERR SHALL abort the transfer with no memory write.

Configuration
REQ-032 Macro AHB_SRAM_ERR_RESP_EN SHALL select error checking.
REQ-033 With the macro defined, an ERROR SHALL be raised for any of: HSIZE > log2(DATAWIDTH/8); HADDR not aligned to 2^HSIZE; HADDR >= MEM_DEPTH*DATAWIDTH/8.
REQ-034 An ERROR SHALL be a two-cycle response: ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), with no memory access.
REQ-035 An ERROR SHALL ignore WAIT_STATES.
REQ-036 Without the macro, HRESP SHALL be tied to 0, ERR1/ERR2 are unreachable, and addresses wrap modulo the memory size.

Verification
REQ-037 DATAWIDTH=32, WAIT_STATES=0: NONSEQ word write 0xDEADBEEF @0x10, then read @0x10 -> HRDATA=0xDEADBEEF one cycle after the read address phase, HRESP=0.
REQ-038 Byte write 0xAA (HSIZE=0) @0x13 over word 0x11223344 -> read @0x10 returns 0xAA223344.
REQ-039 WAIT_STATES=3: single read -> HREADYOUT low exactly 3 cycles, then high with valid data.
REQ-040 Back-to-back write 0x5 @0x20 then read @0x20 -> read returns 0x5 (forwarding).
REQ-041 With AHB_SRAM_ERR_RESP_EN, MEM_DEPTH=256, read @0x400 -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; without the macro -> OKAY returning word 0.
REQ-042 HRESET asserted during the second WAIT cycle of a write -> next cycle HREADYOUT=1, HRESP=0, and a subsequent read shows the target word unchanged.
